// File: rtl/audio_seq_pkg.sv
// Shared state encoding and widths for the audio sample sequencer.
package audio_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    INIT_WAIT = 3'd2,
    FETCH     = 3'd3,
    LOAD      = 3'd4,
    PLAY      = 3'd5
  } audio_seq_state_t;

  localparam int ATTEN_W = 3;
  localparam int CNT_W   = 8;

endpackage

// File: rtl/audio_seq_sample_fmt.sv
// Combinational ROM word formatter: channel split, mono duplication and,
// when AUDIO_SEQ_ATTEN_EN is defined, a sign-preserving right-shift attenuation.
module audio_seq_sample_fmt
  import audio_seq_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int NUM_CH   = 2
) (
  input  logic [NUM_CH*SAMPLE_W-1:0] rom_data,
`ifdef AUDIO_SEQ_ATTEN_EN
  input  logic [ATTEN_W-1:0]         atten,
`endif
  output logic [SAMPLE_W-1:0]        left,
  output logic [SAMPLE_W-1:0]        right
);

  logic [SAMPLE_W-1:0] raw_left;
  logic [SAMPLE_W-1:0] raw_right;

  if (NUM_CH == 1) begin : g_mono
    assign raw_left  = rom_data[SAMPLE_W-1:0];
    assign raw_right = rom_data[SAMPLE_W-1:0];
  end else begin : g_stereo
    // Left channel lives in the upper half of a stereo word.
    assign raw_left  = rom_data[NUM_CH*SAMPLE_W-1 -: SAMPLE_W];
    assign raw_right = rom_data[SAMPLE_W-1:0];
  end

`ifdef AUDIO_SEQ_ATTEN_EN
  assign left  = $signed(raw_left)  >>> atten;
  assign right = $signed(raw_right) >>> atten;
`else
  assign left  = raw_left;
  assign right = raw_right;
`endif

endmodule

// File: rtl/audio_sample_sequencer.sv
// Brings the codec up once, then streams a ROM sample table into audio_interface.
// Optional attenuation input is enabled by defining AUDIO_SEQ_ATTEN_EN.
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 10,
  parameter int NUM_CH   = 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [ADDR_W-1:0]          length,
`ifdef AUDIO_SEQ_ATTEN_EN
  input  logic [ATTEN_W-1:0]         atten,
`endif
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [NUM_CH*SAMPLE_W-1:0] rom_data,
  output logic                       codec_init,
  input  logic                       init_finish,
  input  logic                       data_over,
  output logic [SAMPLE_W-1:0]        ldata,
  output logic [SAMPLE_W-1:0]        rdata,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           loop_count,
  output logic [CNT_W-1:0]           underrun_cnt
);

  audio_seq_state_t    state, state_next;
  logic [ADDR_W-1:0]   idx, len_q;
  logic                loop_q, codec_ready, abort_pend;
  logic                accept, last;
  logic [SAMPLE_W-1:0] fmt_left, fmt_right;
`ifdef AUDIO_SEQ_ATTEN_EN
  logic [ATTEN_W-1:0]  atten_q;
`endif

  assign accept = (state == IDLE) && start && !stop;
  assign last   = (idx == len_q - 1'b1);
  assign busy   = (state != IDLE);

  audio_seq_sample_fmt #(
    .SAMPLE_W (SAMPLE_W),
    .NUM_CH   (NUM_CH)
  ) u_fmt (
    .rom_data (rom_data),
`ifdef AUDIO_SEQ_ATTEN_EN
    .atten    (atten_q),
`endif
    .left     (fmt_left),
    .right    (fmt_right)
  );

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: defaults are assigned before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    codec_init = 1'b0;
    case (state)
      IDLE:      if (accept && length != '0) state_next = codec_ready ? FETCH : INIT;
      INIT: begin
        codec_init = 1'b1;
        state_next = INIT_WAIT;
      end
      INIT_WAIT: if (init_finish) state_next = (abort_pend || stop) ? IDLE : FETCH;
      FETCH:     state_next = stop ? IDLE : LOAD;
      LOAD:      state_next = stop ? IDLE : PLAY;
      PLAY: begin
        if (stop)                             state_next = IDLE;
        else if (data_over && last && !loop_q) state_next = IDLE;
        else if (data_over)                    state_next = FETCH;
      end
      default:   state_next = IDLE;
    endcase
  end

  // rom_addr is loaded on every edge that enters FETCH, so it is valid throughout FETCH.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx          <= '0;
      len_q        <= '0;
      loop_q       <= 1'b0;
      codec_ready  <= 1'b0;
      abort_pend   <= 1'b0;
      rom_addr     <= '0;
      ldata        <= '0;
      rdata        <= '0;
      done         <= 1'b0;
      loop_count   <= '0;
      underrun_cnt <= '0;
`ifdef AUDIO_SEQ_ATTEN_EN
      atten_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          len_q        <= length;
          loop_q       <= loop_en;
          idx          <= '0;
          done         <= (length == '0);
          loop_count   <= '0;
          underrun_cnt <= '0;
          abort_pend   <= 1'b0;
`ifdef AUDIO_SEQ_ATTEN_EN
          atten_q      <= atten;
`endif
          if (length != '0 && codec_ready) rom_addr <= '0;
        end
        INIT: if (stop) abort_pend <= 1'b1;
        INIT_WAIT: begin
          if (stop) abort_pend <= 1'b1;
          if (init_finish) begin
            codec_ready <= 1'b1;
            abort_pend  <= 1'b0;
            rom_addr    <= idx;
          end
        end
        FETCH: if (stop) begin
          ldata <= '0;
          rdata <= '0;
        end
        LOAD: begin
          ldata <= stop ? '0 : fmt_left;
          rdata <= stop ? '0 : fmt_right;
        end
        PLAY: begin
          if (stop) begin
            ldata <= '0;
            rdata <= '0;
          end else if (data_over) begin
            if (!last) begin
              idx      <= idx + 1'b1;
              rom_addr <= idx + 1'b1;
            end else if (loop_q) begin
              idx        <= '0;
              rom_addr   <= '0;
              loop_count <= loop_count + 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // A consume pulse outside PLAY means the interface outran the sequencer.
      if (state != IDLE && state != PLAY && data_over && underrun_cnt != '1)
        underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

endmodule
